// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Register scoreboard and interlock controller for the bexkat1
//             decode stage. A 2-bit counter per register tracks in-flight
//             writes; decode is stalled on RAW hazards against pending
//             registers and on WAW hazards against any pending destination.
//             Counter encoding: 0 idle, 1/2 cycles left until commit,
//             3 waiting for the writeback port.
//  Options  : HAZARD_FWD_EN - when defined, a register one cycle from commit
//             (cnt == 1) is served by the execute-stage bypass instead of
//             stalling, and fwd1_o/fwd2_o flag which operands use it.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int NREGS = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    input  logic             issue_rd1_en_i,
    input  logic             issue_rd2_en_i,
    input  logic [3:0]       issue_rd1_i,
    input  logic [3:0]       issue_rd2_i,
    input  logic             issue_wr_en_i,
    input  logic [3:0]       issue_wr_addr_i,
    input  logic [1:0]       issue_lat_i,
    input  logic             wb_valid_i,
    input  logic [3:0]       wb_addr_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             issue_ack_o,
    output logic             fwd1_o,
    output logic             fwd2_o,
    output logic [NREGS-1:0] busy_o
);

    localparam int   c_NADDR    = 16;
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd3;

    // Per-register state
    logic [NREGS-1:0][1:0]   cnt_q;
    logic [NREGS-1:0][1:0]   cnt_d;
    logic [NREGS-1:0]        busy_q;
    logic [NREGS-1:0]        busy_d;

    // Full 16-entry view of the counters; untracked addresses read as idle
    logic [c_NADDR-1:0][1:0] w_cnt_view;

    logic [1:0] w_cnt_rd1;
    logic [1:0] w_cnt_rd2;
    logic [1:0] w_cnt_wr;
    logic       w_blk_rd1;
    logic       w_blk_rd2;
    logic       w_haz_rd1;
    logic       w_haz_rd2;
    logic       w_haz_waw;
    logic       w_stall;
    logic       w_ack;

    // Widen the counter array to the full 4-bit address space
    always_comb begin
        w_cnt_view = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_cnt_view[r] = cnt_q[r];
        end
    end

    assign w_cnt_rd1 = w_cnt_view[issue_rd1_i];
    assign w_cnt_rd2 = w_cnt_view[issue_rd2_i];
    assign w_cnt_wr  = w_cnt_view[issue_wr_addr_i];

`ifdef HAZARD_FWD_EN
    // A value one cycle from commit is available on the bypass
    assign w_blk_rd1 = (w_cnt_rd1 >= 2'd2);
    assign w_blk_rd2 = (w_cnt_rd2 >= 2'd2);
    assign fwd1_o    = issue_valid_i & issue_rd1_en_i & (w_cnt_rd1 == 2'd1);
    assign fwd2_o    = issue_valid_i & issue_rd2_en_i & (w_cnt_rd2 == 2'd1);
`else
    // No bypass: any pending write blocks the read
    assign w_blk_rd1 = (w_cnt_rd1 != c_IDLE);
    assign w_blk_rd2 = (w_cnt_rd2 != c_IDLE);
    assign fwd1_o    = 1'b0;
    assign fwd2_o    = 1'b0;
`endif

    assign w_haz_rd1 = issue_rd1_en_i & w_blk_rd1;
    assign w_haz_rd2 = issue_rd2_en_i & w_blk_rd2;
    // Rewriting a pending register would let writebacks reorder
    assign w_haz_waw = issue_wr_en_i & (w_cnt_wr != c_IDLE);

    assign w_stall = stall_i | (issue_valid_i & (w_haz_rd1 | w_haz_rd2 | w_haz_waw));
    // Nothing is accepted on a cycle whose edge discards all tracking
    assign w_ack   = issue_valid_i & ~w_stall & ~flush_i & ~rst_i;

    assign stall_o     = w_stall;
    assign issue_ack_o = w_ack;
    assign busy_o      = busy_q;

    // Counter next state: flush, then new issue, then writeback, then countdown
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (flush_i) begin
                cnt_d[r] = c_IDLE;
            end else if (w_ack && issue_wr_en_i && (issue_wr_addr_i == 4'(r))) begin
                cnt_d[r] = issue_lat_i;
            end else if ((cnt_q[r] == c_WAIT) && wb_valid_i && (wb_addr_i == 4'(r))) begin
                cnt_d[r] = c_IDLE;
            end else if ((cnt_q[r] == 2'd1 || cnt_q[r] == 2'd2) && !stall_i) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
            busy_d[r] = (cnt_d[r] != c_IDLE);
        end
    end

    // Scoreboard state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            busy_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Register scoreboard and interlock controller for the bexkat1 pipeline. It sits beside the decode stage and tracks, per architectural register, whether a write is still in flight. It drives the decode-stage stall whenever an issuing instruction reads or rewrites a pending register, so the register file is never read stale and writebacks stay in order. Long-latency (memory) writes are held until the writeback port reports completion.

## Interface
- NREGS, default 16: number of tracked registers; the address width is fixed at 4 bits.
- clk_i  input  1  pipeline clock.
- rst_i  input  1  reset; synchronous, active-high.
- issue_valid_i  input  1  decode holds a valid instruction this cycle.
- issue_rd1_en_i, issue_rd2_en_i  input  1 each  the instruction uses read port 1 or 2.
- issue_rd1_i, issue_rd2_i  input  4 each  read addresses (same selection as the register file: rb/rc, or ra/rb for T_CMP).
- issue_wr_en_i  input  1  the instruction writes a register.
- issue_wr_addr_i  input  4  destination register (ra).
- issue_lat_i  input  2  write latency in cycles after issue (0, 1 or 2); 3 means unknown, wait for writeback.
- wb_valid_i  input  1  writeback port commits a write this cycle.
- wb_addr_i  input  4  register being committed.
- stall_i  input  1  downstream stall (execute/memory frozen).
- flush_i  input  1  pipeline restart; discard all tracking.
- stall_o  output  1  hold decode/fetch this cycle.
- issue_ack_o  output  1  the instruction is accepted this cycle.
- fwd1_o, fwd2_o  output  1 each  operand is taken from the bypass, not the register file.
- busy_o  output  16  bit r set when cnt[r] != 0.

## Operation
- State: cnt[r], 2 bits per register. 0 = idle; 1 and 2 = cycles until the write commits; 3 = waiting for wb_valid_i.
- Read hazard on port p: issue_rdp_en_i && blocked(cnt[issue_rdp_i]).
  - Without the forwarding feature, blocked means cnt != 0.
  - With it, blocked means cnt >= 2.
- WAW hazard: issue_wr_en_i && cnt[issue_wr_addr_i] != 0, with or without forwarding.
- stall_o = stall_i | (issue_valid_i & (rd1 hazard | rd2 hazard | WAW hazard)).
- issue_ack_o = issue_valid_i & ~stall_o & ~flush_i.
- Per-register next state, highest priority first:
  - rst_i or flush_i: 0.
  - issue_ack_o && issue_wr_en_i && issue_wr_addr_i == r: issue_lat_i.
  - cnt == 3 && wb_valid_i && wb_addr_i == r: 0.
  - cnt in {1,2} && !stall_i: cnt − 1.
  - Otherwise: hold.
- wb_valid_i matching a register whose cnt is 0, 1 or 2 is ignored. Counters 1 and 2 retire by countdown only.
- Issue with issue_lat_i = 0 leaves cnt at 0.

## Timing
- stall_o, issue_ack_o, fwd1_o and fwd2_o are combinational from the inputs and current state, valid in the same cycle.
- busy_o and cnt are registered; an update is visible the cycle after the triggering edge.
- Reset values: every cnt 0 and busy_o 0.
  - With issue_valid_i = 0 and stall_i = 0: stall_o 0, issue_ack_o 0, fwd1_o 0, fwd2_o 0.
- A dependent instruction issued after a writer with latency L stalls for exactly L cycles without forwarding, or L − 1 cycles with forwarding.
  - Applies for L ≤ 2 and stall_i low.
- A latency-3 entry stalls dependents until the cycle after the matching wb_valid_i.
- stall_i freezes countdown; entries at 3 can still be cleared by writeback during stall_i.
- If reset or flush arrives mid-operation, all entries clear on that edge and no issue is accepted in that cycle.

## Configuration
- HAZARD_FWD_EN defined: cnt == 1 is not a read hazard.
  - fwd1_o / fwd2_o = issue_valid_i & issue_rdp_en_i & (cnt[issue_rdp_i] == 1).
  - The execute stage selects its bypass operand on fwdp.
- HAZARD_FWD_EN undefined: any nonzero cnt is a read hazard, and fwd1_o / fwd2_o are tied 0.

## Test plan
- Issue a write to r3 with lat 2, then the next cycle a read of r3 on port 1 (no FWD).
  - Required: stall_o high for 2 cycles, ack on the 3rd, busy_o[3] set for 2 cycles.
- Same stimulus with HAZARD_FWD_EN.
  - Required: 1 stall cycle, then ack with fwd1_o = 1.
- Issue a load to r5 with lat 3; keep issuing reads of r5; pulse wb_valid_i with addr 5 after 6 cycles.
  - Required: stall throughout, ack on the cycle after wb; wb with addr 4 has no effect.
- Writer to r2 with lat 2, then hold stall_i for 3 cycles.
  - Required: cnt[2] stays 1 while stall_i is high, then reaches 0 one cycle after release.
- Issue to r7 with lat 2 in the same cycle as a WAW check on r7 with cnt == 1.
  - Required: stall (WAW); after r7 drains, re-issue sets cnt[7] = 2.
- busy_o = 16'h00A4 when flush_i or rst_i is asserted with issue_valid_i high.
  - Required: busy_o = 0 next cycle and issue_ack_o = 0 in the flush cycle.
